// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: sequences a 16 x 8 synchronous RAM. It does block fills of
// addresses 0..15 from a valid/ready input stream, and block read-outs of
// addresses 0..15 onto a valid/ready output stream.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   fill_start        start a fill (wins over dump_start if both are high)
//   in_data/valid/rdy fill input stream
//   dump_start        start a read-out
//   out_data/valid/rdy read-out stream (out_data registered)
//   ram_din/addr/wr_en/ram_out  RAM port (ram_out is valid one clk after addr)
//   busy              high whenever not idle
//   done              one-cycle pulse after the final fill/dump handshake
//   chk_err           read-out checksum mismatch
//
// Build option: define RAM_SEQ_CHECKSUM_EN to compare the XOR of the words
// handed out by each dump against the XOR of the last completed fill.
// Without it, chk_err is tied low.
module ram_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       fill_start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       dump_start,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] ram_din,
  output logic [3:0] ram_addr,
  output logic       ram_wr_en,
  input  logic [7:0] ram_out,
  output logic       busy,
  output logic       done,
  output logic       chk_err
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFill   = 3'd1,
    StRdAddr = 3'd2,
    StRdCap  = 3'd3,
    StRdOut  = 3'd4
  } state_e;

  state_e     state_q;
  logic [3:0] ptr_q;
  logic [7:0] out_data_q;
  logic       done_q;

  logic fill_hs;
  logic dump_hs;
  logic last_word;
  logic fill_go;
  logic dump_go;

  always_comb begin
    fill_hs   = (state_q == StFill) && in_valid;
    dump_hs   = (state_q == StRdOut) && out_ready;
    last_word = (ptr_q == 4'hF);
    fill_go   = (state_q == StIdle) && fill_start;
    dump_go   = (state_q == StIdle) && dump_start && !fill_start;
  end

  // Status outputs decode straight from the state register.
  assign in_ready  = (state_q == StFill);
  assign out_valid = (state_q == StRdOut);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign out_data  = out_data_q;

  // ptr_q is 0 in idle, so the address needs no separate idle term.
  assign ram_addr  = ptr_q;
  assign ram_din   = in_data;
  assign ram_wr_en = fill_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= 4'd0;
      out_data_q <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          ptr_q <= 4'd0;
          if (fill_go) begin
            state_q <= StFill;
          end else if (dump_go) begin
            state_q <= StRdAddr;
          end
        end
        StFill: begin
          if (fill_hs) begin
            ptr_q <= ptr_q + 4'd1;  // wraps to 0 after the last word
            if (last_word) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        StRdAddr: state_q <= StRdCap;
        StRdCap: begin
          out_data_q <= ram_out;
          state_q    <= StRdOut;
        end
        StRdOut: begin
          if (dump_hs) begin
            ptr_q <= ptr_q + 4'd1;
            if (last_word) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRdAddr;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          ptr_q   <= 4'd0;
        end
      endcase
    end
  end

`ifdef RAM_SEQ_CHECKSUM_EN
  // A single accumulator serves both fill and dump, since they never overlap.
  logic [7:0] acc_q;
  logic [7:0] store_q;
  logic       chk_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= 8'd0;
      store_q   <= 8'd0;
      chk_err_q <= 1'b0;
    end else begin
      if (fill_go) begin
        acc_q <= 8'd0;
      end else if (dump_go) begin
        acc_q     <= 8'd0;
        chk_err_q <= 1'b0;
      end
      if (fill_hs) begin
        acc_q <= acc_q ^ in_data;
        if (last_word) begin
          store_q <= acc_q ^ in_data;
        end
      end
      if (dump_hs) begin
        acc_q <= acc_q ^ out_data_q;
        if (last_word) begin
          chk_err_q <= ((acc_q ^ out_data_q) != store_q);
        end
      end
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl with a behavioural 16 x 8 synchronous RAM.
module tb_ram_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fill_start = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       dump_start = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] ram_din;
  logic [3:0] ram_addr;
  logic       ram_wr_en;
  logic [7:0] ram_out;
  logic       busy;
  logic       done;
  logic       chk_err;

  int errors = 0;
  int checks = 0;

  // RAM model: write-through on wr_en, read data one clock after the address.
  logic [7:0] mem [16];
  logic [7:0] ram_rd_q = 8'd0;
  bit         corrupt3 = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_din;
    ram_rd_q <= (corrupt3 && ram_addr == 4'd3) ? 8'h00 : mem[ram_addr];
  end
  assign ram_out = ram_rd_q;

  ram_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dump_start (dump_start),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ram_din    (ram_din),
    .ram_addr   (ram_addr),
    .ram_wr_en  (ram_wr_en),
    .ram_out    (ram_out),
    .busy       (busy),
    .done       (done),
    .chk_err    (chk_err)
  );

  // Results collected by run_dump.
  logic [7:0] got_words [16];
  int got_n, got_cycles, first_valid, hold_bad, hold_seen, wr_bad;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_fill(input logic [7:0] base, input logic [7:0] step);
    tick(); fill_start = 1'b1;
    tick(); fill_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i) * step;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Runs one dump; cycle 0 is the first cycle after dump_start is sampled.
  task automatic run_dump(input bit toggle);
    int cyc;
    bit stall;
    logic [7:0] held;
    got_n = 0; hold_bad = 0; hold_seen = 0; wr_bad = 0; first_valid = -1;
    stall = 1'b0; held = 8'd0;
    tick(); dump_start = 1'b1; out_ready = 1'b1;
    tick(); dump_start = 1'b0;
    cyc = 0;
    while (!done && cyc < 400) begin
      out_ready = toggle ? (((cyc / 4) % 2) == 0) : 1'b1;
      if (stall) begin
        hold_seen++;
        if (!out_valid || out_data !== held) hold_bad++;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (ram_wr_en) wr_bad++;
      if (out_valid && out_ready) begin
        if (got_n < 16) got_words[got_n] = out_data;
        got_n++;
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      tick();
      cyc++;
    end
    got_cycles = cyc;
    out_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b want=0", ram_wr_en); end
    checks++; if (ram_addr !== 4'd0) begin errors++; $display("FAIL rst_addr got=%h want=0", ram_addr); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL rst_out_data got=%h want=00", out_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL rst_chk_err got=%b want=0", chk_err); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    tick(); fill_start = 1'b1; in_valid = 1'b1; in_data = 8'h00; #1;
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL fill_idle_wr got=%b want=0", ram_wr_en); end
    tick(); fill_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i); #1;
      checks++; if (ram_wr_en !== 1'b1) begin errors++; $display("FAIL fill_wr[%0d] got=%b want=1", i, ram_wr_en); end
      checks++; if (ram_addr !== 4'(i)) begin errors++; $display("FAIL fill_addr[%0d] got=%h want=%h", i, ram_addr, 4'(i)); end
      checks++; if (ram_din !== 8'(i)) begin errors++; $display("FAIL fill_din[%0d] got=%h want=%h", i, ram_din, 8'(i)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%b want=1", i, in_ready); end
      tick();
    end
    // in_valid still high here: idle must not write.
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fill_done got=%b want=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_busy_at_done got=%b want=0", busy); end
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL fill_post_wr got=%b want=0", ram_wr_en); end
    checks++; if (ram_addr !== 4'd0) begin errors++; $display("FAIL fill_post_addr got=%h want=0", ram_addr); end
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (mem[i] !== 8'(i)) begin errors++; $display("FAIL fill_mem[%0d] got=%h want=%h", i, mem[i], 8'(i)); end
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fill_done_width got=%b want=0", done); end
  endtask

  task automatic test_dump();
    run_dump(1'b0);
    checks++; if (got_n !== 16) begin errors++; $display("FAIL dump_count got=%0d want=16", got_n); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_words[i] !== 8'(i)) begin errors++; $display("FAIL dump_word[%0d] got=%h want=%h", i, got_words[i], 8'(i)); end
    end
    // out_valid appears in the third cycle after the one presenting dump_start.
    checks++; if (first_valid !== 2) begin errors++; $display("FAIL dump_first_valid got=%0d want=2", first_valid); end
    checks++; if (got_cycles !== 48) begin errors++; $display("FAIL dump_cycles got=%0d want=48", got_cycles); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dump_done got=%b want=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dump_busy_at_done got=%b want=0", busy); end
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL dump_chk_err got=%b want=0", chk_err); end
    checks++; if (wr_bad !== 0) begin errors++; $display("FAIL dump_wr_en got=%0d want=0", wr_bad); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dump_done_width got=%b want=0", done); end
  endtask

  task automatic test_backpressure();
    run_dump(1'b1);
    checks++; if (got_n !== 16) begin errors++; $display("FAIL bp_count got=%0d want=16", got_n); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_words[i] !== 8'(i)) begin errors++; $display("FAIL bp_word[%0d] got=%h want=%h", i, got_words[i], 8'(i)); end
    end
    checks++; if (hold_seen == 0) begin errors++; $display("FAIL bp_stalls got=%0d want>0", hold_seen); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold got=%0d want=0", hold_bad); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b want=1", done); end
  endtask

  task automatic test_start_priority();
    tick(); fill_start = 1'b1; dump_start = 1'b1;
    tick(); fill_start = 1'b0; dump_start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_fill got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prio_out_valid got=%b want=0", out_valid); end
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        in_valid = 1'b0; dump_start = 1'b0; #1;
        checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr got=%b want=0", ram_wr_en); end
        checks++; if (ram_addr !== 4'd8) begin errors++; $display("FAIL stall_addr got=%h want=8", ram_addr); end
        tick();
      end
      in_valid   = 1'b1;
      in_data    = 8'h10 + 8'(i);
      dump_start = (i == 5);
      #1;
      checks++; if (ram_addr !== 4'(i)) begin errors++; $display("FAIL prio_addr[%0d] got=%h want=%h", i, ram_addr, 4'(i)); end
      tick();
    end
    in_valid = 1'b0; dump_start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL prio_done got=%b want=1", done); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_dump_ignored got=%b want=0", busy); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (mem[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL prio_mem[%0d] got=%h want=%h", i, mem[i], 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_reset_mid_fill();
    tick(); fill_start = 1'b1;
    tick(); fill_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'h40 + 8'(i);
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr got=%b want=0", ram_wr_en); end
    checks++; if (ram_addr !== 4'd0) begin errors++; $display("FAIL rstmid_addr got=%h want=0", ram_addr); end
    checks++; if (mem[6] !== 8'h46) begin errors++; $display("FAIL rstmid_mem6 got=%h want=46", mem[6]); end
    checks++; if (mem[7] !== 8'h17) begin errors++; $display("FAIL rstmid_mem7 got=%h want=17", mem[7]); end
    in_valid = 1'b0;
    tick(); fill_start = 1'b1;
    tick(); fill_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'h80 + 8'(i); #1;
      checks++; if (ram_addr !== 4'(i)) begin errors++; $display("FAIL refill_addr[%0d] got=%h want=%h", i, ram_addr, 4'(i)); end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL refill_done got=%b want=1", done); end
    checks++; if (mem[0] !== 8'h80) begin errors++; $display("FAIL refill_mem0 got=%h want=80", mem[0]); end
    checks++; if (mem[15] !== 8'h8f) begin errors++; $display("FAIL refill_mem15 got=%h want=8f", mem[15]); end
  endtask

  task automatic test_checksum();
    logic exp_err;
    int   cyc;
`ifdef RAM_SEQ_CHECKSUM_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_fill(8'hA5, 8'h00);
    corrupt3 = 1'b1;
    run_dump(1'b0);
    corrupt3 = 1'b0;
    checks++; if (got_n !== 16) begin errors++; $display("FAIL cks_count got=%0d want=16", got_n); end
    checks++; if (got_words[3] !== 8'h00) begin errors++; $display("FAIL cks_word3 got=%h want=00", got_words[3]); end
    checks++; if (got_words[4] !== 8'hA5) begin errors++; $display("FAIL cks_word4 got=%h want=a5", got_words[4]); end
    checks++; if (chk_err !== exp_err) begin errors++; $display("FAIL cks_err got=%b want=%b", chk_err, exp_err); end
    repeat (3) tick();
    checks++; if (chk_err !== exp_err) begin errors++; $display("FAIL cks_err_held got=%b want=%b", chk_err, exp_err); end
    // A new accepted dump clears the flag; a clean dump leaves it low.
    dump_start = 1'b1;
    tick(); dump_start = 1'b0;
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL cks_clear got=%b want=0", chk_err); end
    cyc = 0;
    while (!done && cyc < 100) begin
      tick(); cyc++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL cks_clean_done got=%b want=1", done); end
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL cks_clean_err got=%b want=0", chk_err); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_dump();
    test_backpressure();
    test_start_priority();
    test_reset_mid_fill();
    test_checksum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_seq_ctrl.md
RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

Interface
REQ-001 Port list SHALL be:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- fill_start  in  1  request block fill of RAM addresses 0..15
- in_data  in  8  fill write data
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts in_data
- dump_start  in  1  request block read-out of RAM addresses 0..15
- out_data  out  8  read-out data, registered
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- ram_din  out  8  to RAM din
- ram_addr  out  4  to RAM addr
- ram_wr_en  out  1  to RAM wr_en
- ram_out  in  8  from RAM out; valid one clk after ram_addr applied with ram_wr_en low
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of fill or dump
- chk_err  out  1  readback checksum mismatch (see Configuration)
REQ-002 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 FSM states SHALL be IDLE, FILL, RD_ADDR, RD_CAP, RD_OUT; 4-bit pointer ptr.
REQ-004 IDLE: in_ready=0, out_valid=0, ram_wr_en=0, ram_addr=0; fill_start -> FILL with ptr=0; dump_start -> RD_ADDR with ptr=0; both same cycle -> FILL wins.
REQ-005 FILL: in_ready=1; ram_addr=ptr; ram_din=in_data; ram_wr_en=in_valid combinationally (write occurs on the handshake edge).
REQ-006 FILL handshake on ptr=15 SHALL wrap ptr to 0, pulse done next cycle, return to IDLE; otherwise ptr increments; no handshake -> hold.
REQ-007 RD_ADDR: ram_addr=ptr, ram_wr_en=0, next state RD_CAP unconditionally.
REQ-008 RD_CAP: ram_addr held at ptr; ram_out captured into out_data at end of cycle; next state RD_OUT.
REQ-009 RD_OUT: out_valid=1, out_data stable until out_valid&&out_ready; on handshake ptr=15 -> IDLE, ptr=0, done pulse; else ptr+1 -> RD_ADDR.
REQ-010 First out_valid SHALL rise 3 clks after dump_start sampled; max throughput 1 word per 3 clks.
REQ-011 fill_start/dump_start SHALL be ignored while busy=1.
REQ-012 ram_wr_en SHALL never be high outside FILL.
REQ-013 done SHALL be high exactly one cycle, the cycle after the final handshake, with busy=0 in that cycle.

Reset
REQ-014 rst SHALL force IDLE, ptr=0, out_data=0, out_valid=0, done=0, chk_err=0, ram_wr_en=0, ram_addr=0 at the next edge, including mid-fill/mid-dump; RAM contents untouched.

Configuration
REQ-015 With RAM_SEQ_CHECKSUM_EN defined: 8-bit XOR of words written in last completed fill stored; XOR of words handed out in dump accumulated; at dump completion chk_err=(mismatch), held until next dump_start accepted or rst.
REQ-016 Without RAM_SEQ_CHECKSUM_EN: chk_err port present, tied 0; no checksum registers.
REQ-017 Fill aborted by rst SHALL clear the stored checksum to 0.

Verification
REQ-018 Fill 0x00..0x0F, in_valid constant 1 -> 16 writes addr 0..15 in 16 consecutive clks, done one clk after, busy low.
REQ-019 Dump after REQ-018 with out_ready=1 -> out_data 0x00..0x0F in order, 48 clks, done pulse, chk_err=0.
REQ-020 Dump with out_ready toggling every 4 clks -> out_data held stable while out_valid&&!out_ready, no word lost or repeated.
REQ-021 fill_start and dump_start same cycle -> FILL entered; dump_start during FILL ignored.
REQ-022 rst asserted after 7th fill write -> next clk IDLE, ram_wr_en=0, ptr=0; new fill restarts at addr 0.
REQ-023 With RAM_SEQ_CHECKSUM_EN: fill 0xA5 x16, bench model forces ram_out=0x00 at addr 3 -> chk_err=1 after dump done; without macro chk_err=0.
